// File: rtl/alu_writeback_sequencer_if.sv
// rtl/alu_writeback_sequencer_if.sv - command and register-file port bundle for alu_writeback_sequencer
// master drives commands and register read data; slave is the sequencer.
interface alu_writeback_sequencer_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [AW-1:0]   cmd_rs1;
  logic [AW-1:0]   cmd_rs2;
  logic [AW-1:0]   cmd_rd;
  logic [2:0]      cmd_op;
  logic [AW-1:0]   readreg1;
  logic [AW-1:0]   readreg2;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [AW-1:0]   writereg;
  logic [XLEN-1:0] data;
  logic            regwrite;
  logic            busy;
  logic            done;
  logic            div_by_zero;

  modport master (
    output cmd_valid, cmd_rs1, cmd_rs2, cmd_rd, cmd_op, a, b,
    input  cmd_ready, readreg1, readreg2, writereg, data, regwrite, busy, done, div_by_zero
  );

  modport slave (
    input  cmd_valid, cmd_rs1, cmd_rs2, cmd_rd, cmd_op, a, b,
    output cmd_ready, readreg1, readreg2, writereg, data, regwrite, busy, done, div_by_zero
  );
endinterface

// File: rtl/alu_writeback_sequencer.sv
// rtl/alu_writeback_sequencer.sv - read/execute/write-back sequencer with iterative unsigned divide
// Optional SEQ_BACK_TO_BACK_EN: accept the next command during WRITE.
module alu_writeback_sequencer #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input logic                      clk,
  input logic                      clr,
  alu_writeback_sequencer_if.slave bus
);
  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_DIV, S_WRITE} state_t;

  state_t          state_q;
  logic [AW-1:0]   rd_q;
  logic [2:0]      op_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [XLEN-1:0] rem_q, quo_q;
  logic [CW-1:0]   cnt_q;
  logic [AW-1:0]   readreg1_q, readreg2_q, writereg_q;
  logic [XLEN-1:0] data_q;
  logic            regwrite_q, done_q, dbz_q, ready_q, busy_q;

  logic            accept;
  logic [XLEN-1:0] alu_d;
  logic [XLEN:0]   trial_d;
  logic            ge_d;
  logic [XLEN-1:0] rem_d, quo_d;

  assign accept = bus.cmd_valid && ready_q;

  // op 011 only reaches this path with a zero divisor, hence all ones
  always_comb begin
    alu_d = '0;
    case (op_q)
      3'b000:  alu_d = a_q + b_q;
      3'b001:  alu_d = a_q - b_q;
      3'b010:  alu_d = a_q * b_q;
      3'b011:  alu_d = '1;
      3'b100:  alu_d = a_q & b_q;
      3'b101:  alu_d = ~a_q;
      3'b110:  alu_d = a_q | b_q;
      default: alu_d = a_q ^ b_q;
    endcase
  end

  // one restoring step: shift the next dividend bit into the partial remainder
  always_comb begin
    trial_d = {rem_q, quo_q[XLEN-1]};
    ge_d    = trial_d >= {1'b0, b_q};
    rem_d   = ge_d ? XLEN'(trial_d - {1'b0, b_q}) : trial_d[XLEN-1:0];
    quo_d   = {quo_q[XLEN-2:0], ge_d};
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= S_IDLE;
      rd_q       <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      readreg1_q <= '0;
      readreg2_q <= '0;
      writereg_q <= '0;
      data_q     <= '0;
      regwrite_q <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      regwrite_q <= 1'b0;
      done_q     <= 1'b0;
      if (accept) begin
        readreg1_q <= bus.cmd_rs1;
        readreg2_q <= bus.cmd_rs2;
        rd_q       <= bus.cmd_rd;
        op_q       <= bus.cmd_op;
        dbz_q      <= 1'b0;
        ready_q    <= 1'b0;
        busy_q     <= 1'b1;
        state_q    <= S_READ;
      end else begin
        case (state_q)
          S_IDLE: begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
          S_READ: begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            state_q <= S_EXEC;
          end
          S_EXEC: begin
            if (op_q == 3'b011 && b_q != '0) begin
              rem_q   <= '0;
              quo_q   <= a_q;
              cnt_q   <= CW'(XLEN);
              state_q <= S_DIV;
            end else begin
              dbz_q      <= (op_q == 3'b011);
              writereg_q <= rd_q;
              data_q     <= alu_d;
              regwrite_q <= (rd_q != '0);
              done_q     <= 1'b1;
              state_q    <= S_WRITE;
`ifdef SEQ_BACK_TO_BACK_EN
              ready_q    <= 1'b1;
`endif
            end
          end
          S_DIV: begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              writereg_q <= rd_q;
              data_q     <= quo_d;
              regwrite_q <= (rd_q != '0);
              done_q     <= 1'b1;
              state_q    <= S_WRITE;
`ifdef SEQ_BACK_TO_BACK_EN
              ready_q    <= 1'b1;
`endif
            end
          end
          default: begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.cmd_ready   = ready_q;
  assign bus.busy        = busy_q;
  assign bus.readreg1    = readreg1_q;
  assign bus.readreg2    = readreg2_q;
  assign bus.writereg    = writereg_q;
  assign bus.data        = data_q;
  assign bus.regwrite    = regwrite_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_alu_writeback_sequencer.sv
// tb/tb_alu_writeback_sequencer.sv - scoreboard bench for alu_writeback_sequencer with a behavioural register file
// Honours SEQ_BACK_TO_BACK_EN for the expected accept spacing.
module tb_alu_writeback_sequencer;
  localparam int XLEN = 32;
  localparam int AW   = 5;
`ifdef SEQ_BACK_TO_BACK_EN
  localparam int GAP = 3;
`else
  localparam int GAP = 4;
`endif

  typedef struct {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
    logic            dbz;
    logic            we;
    int              lat;
  } exp_t;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  alu_writeback_sequencer_if #(.XLEN(XLEN), .AW(AW)) bus ();
  alu_writeback_sequencer #(.XLEN(XLEN), .AW(AW)) dut (.clk(clk), .clr(clr), .bus(bus));

  logic [XLEN-1:0] rf   [32];
  logic [XLEN-1:0] gold [32];
  logic            pre_we;
  logic [AW-1:0]   pre_addr;
  logic [XLEN-1:0] pre_data;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_acc    = 0;
  int   acc_edge = 0;
  int   acc_prev = 0;
  int   retired  = 0;

  assign bus.a = rf[bus.readreg1];
  assign bus.b = rf[bus.readreg2];

  // a write sampled while clr is high is dropped, like the real register file
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pre_we) rf[pre_addr] <= pre_data;
    else if (bus.regwrite && !clr) rf[bus.writereg] <= bus.data;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] model(input logic [2:0] op, input logic [XLEN-1:0] x,
                                            input logic [XLEN-1:0] y, output logic dz);
    dz = 1'b0;
    case (op)
      3'b000: return x + y;
      3'b001: return x - y;
      3'b010: return x * y;
      3'b011: begin
        if (y == '0) begin
          dz = 1'b1;
          return '1;
        end
        return x / y;
      end
      3'b100: return x & y;
      3'b101: return ~x;
      3'b110: return x | y;
      default: return x ^ y;
    endcase
  endfunction

  always @(negedge clk) begin
    if (bus.done || bus.regwrite) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("done", bus.done, 1);
        check_eq("writereg", bus.writereg, e.rd);
        check_eq("data", bus.data, e.data);
        check_eq("regwrite", bus.regwrite, e.we);
        check_eq("div_by_zero", bus.div_by_zero, e.dbz);
        check_eq("latency", cyc + 1 - acc_edge, e.lat);
      end
      retired++;
    end
    if (bus.cmd_valid && bus.cmd_ready && !clr) begin
      acc_prev = acc_edge;
      acc_edge = cyc + 1;
      n_acc++;
    end
  end

  task automatic set_reg(input int idx, input logic [XLEN-1:0] v);
    pre_addr = AW'(idx);
    pre_data = v;
    pre_we   = 1'b1;
    @(posedge clk);
    #1 pre_we = 1'b0;
    gold[idx] = v;
  endtask

  task automatic issue(input logic [2:0] op, input int s1, input int s2, input int d, input bit track);
    exp_t e;
    logic dz;
    int   start;
    if (track) begin
      e.data = model(op, gold[s1], gold[s2], dz);
      e.rd   = AW'(d);
      e.dbz  = dz;
      e.we   = (d != 0);
      e.lat  = (op == 3'b011 && gold[s2] != '0) ? XLEN + 3 : 3;
      sb.push_back(e);
      if (d != 0) gold[d] = e.data;
    end
    bus.cmd_op    = op;
    bus.cmd_rs1   = AW'(s1);
    bus.cmd_rs2   = AW'(s2);
    bus.cmd_rd    = AW'(d);
    bus.cmd_valid = 1'b1;
    start = n_acc;
    for (int i = 0; i < 100 && n_acc == start; i++) @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    if (n_acc == start) check_eq("accept_timeout", 0, 1);
  endtask

  task automatic wait_retire(input int target, output int rdy);
    rdy = 0;
    for (int i = 0; i < 200 && retired < target; i++) begin
      @(negedge clk);
      if (bus.busy && !bus.done && bus.cmd_ready) rdy++;
    end
    if (retired < target) check_eq("retire_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [2:0] op, input int s1, input int s2, input int d, output int rdy);
    int tgt;
    tgt = retired + 1;
    issue(op, s1, s2, d, 1'b1);
    wait_retire(tgt, rdy);
  endtask

  initial begin
    int rdy;
    int tgt;
    clr = 1'b1;
    pre_we = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = '0;
    bus.cmd_rs1 = '0;
    bus.cmd_rs2 = '0;
    bus.cmd_rd = '0;
    repeat (3) @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    check_eq("rst_cmd_ready", bus.cmd_ready, 1);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_regwrite", bus.regwrite, 0);
    check_eq("rst_dbz", bus.div_by_zero, 0);
    check_eq("rst_readreg1", bus.readreg1, 0);
    check_eq("rst_readreg2", bus.readreg2, 0);
    check_eq("rst_writereg", bus.writereg, 0);
    check_eq("rst_data", bus.data, 0);
    repeat (20) begin
      @(negedge clk);
      check_eq("idle_regwrite", bus.regwrite, 0);
    end

    for (int i = 0; i < 16; i++) set_reg(i, '0);
    set_reg(1, 7);
    set_reg(2, 5);
    run_op(3'b000, 1, 2, 3, rdy);
    run_op(3'b001, 1, 2, 4, rdy);
    set_reg(1, 5);
    set_reg(2, 7);
    run_op(3'b001, 1, 2, 4, rdy);
    set_reg(5, 32'h0001_0000);
    set_reg(6, 32'h0001_0000);
    run_op(3'b010, 5, 6, 7, rdy);
    set_reg(8, 100);
    set_reg(9, 7);
    run_op(3'b011, 8, 9, 10, rdy);
    check_eq("div_ready_low", rdy, 0);
    run_op(3'b011, 8, 11, 12, rdy);
    run_op(3'b111, 1, 2, 0, rdy);
    run_op(3'b100, 1, 2, 13, rdy);
    run_op(3'b101, 1, 2, 14, rdy);
    run_op(3'b110, 1, 2, 15, rdy);

    // abort a divide mid-flight; nothing may retire from it
    issue(3'b011, 8, 9, 10, 1'b0);
    repeat (10) @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    check_eq("abort_ready", bus.cmd_ready, 1);
    check_eq("abort_busy", bus.busy, 0);
    repeat (40) @(negedge clk);
    check_eq("abort_regwrite", bus.regwrite, 0);
    run_op(3'b000, 1, 2, 3, rdy);

    // reset wins over a simultaneous command
    @(posedge clk);
    #1 clr = 1'b1;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check_eq("clr_vs_valid_busy", bus.busy, 0);

    set_reg(1, 7);
    set_reg(2, 5);
    tgt = retired + 2;
    issue(3'b000, 1, 2, 3, 1'b1);
    issue(3'b000, 3, 3, 4, 1'b1);
    wait_retire(tgt, rdy);
    check_eq("b2b_gap", acc_edge - acc_prev, GAP);
    check_eq("b2b_r4", rf[4], 24);

    for (int i = 0; i < 16; i++) check_eq($sformatf("rf_r%0d", i), rf[i], gold[i]);
    check_eq("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
